// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, register map
// and STATUS field layout.
package intr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } intr_state_e;

  localparam logic [1:0] ADDR_ENABLE   = 2'd0;
  localparam logic [1:0] ADDR_PENDING  = 2'd1;
  localparam logic [1:0] ADDR_VEC_BASE = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  localparam int GIE_BIT          = 31;
  localparam int STATUS_STATE_LSB = 0;
  localparam int STATUS_ID_LSB    = 8;
  localparam int STATUS_ID_W      = 5;

  function automatic logic [31:0] pack_status(intr_state_e st, logic [STATUS_ID_W-1:0] id);
    return (32'(st) << STATUS_STATE_LSB) | (32'(id) << STATUS_ID_LSB);
  endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// Core-facing bus of the interrupt controller: configuration port plus the
// request/acknowledge/done handshake.
interface intr_ctrl_if #(
  parameter int ID_W = 3
);
  // Handshake: irq_req_o stays high with irq_id_o/irq_vector_o stable until the
  // core samples it with irq_ack_i=1 on a rising clk edge (or the controller
  // withdraws it); irq_done_i then closes the service window. Acks outside a
  // request and dones outside service are ignored.
  logic            cfg_we_i;
  logic [1:0]      cfg_addr_i;
  logic [31:0]     cfg_wdata_i;
  logic [31:0]     cfg_rdata_o;
  logic            irq_req_o;
  logic [ID_W-1:0] irq_id_o;
  logic [31:0]     irq_vector_o;
  logic            irq_ack_i;
  logic            irq_done_i;

  modport master (
    output cfg_we_i, cfg_addr_i, cfg_wdata_i, irq_ack_i, irq_done_i,
    input  cfg_rdata_o, irq_req_o, irq_id_o, irq_vector_o
  );

  modport slave (
    input  cfg_we_i, cfg_addr_i, cfg_wdata_i, irq_ack_i, irq_done_i,
    output cfg_rdata_o, irq_req_o, irq_id_o, irq_vector_o
  );

endinterface

// File: rtl/intr_prio_enc.sv
// Combinational lowest-index-wins priority encoder.
module intr_prio_enc #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic [ID_W-1:0]    idx_o,
  output logic               valid_o
);

  // Scanning downward lets the lowest set index overwrite any higher one.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = ID_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Edge-triggered interrupt controller: synchronizes source lines, latches
// pending edges and hands the lowest enabled one to the core, one at a time.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_i,
  intr_ctrl_if.slave         bus,
  output intr_state_e        dbg_state_o
);

  logic [NUM_SRC-1:0] sync1_q, sync2_q, hist_q, edge_det;
  logic [NUM_SRC-1:0] en_q, pend_q, pend_d, masked;
  logic [NUM_SRC-1:0] clr_w1c, clr_ack;
  logic               gie_q;
  logic [31:0]        vec_q;
  intr_state_e        state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d, enc_idx;
  logic               enc_valid, req_q, req_d, ack_fire, id_live;
  logic               wr_en, wr_pend, wr_vec;

  // Lines are asynchronous; hist_q resets to 0 so a line already high at
  // reset release still registers as an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign edge_det = sync2_q & ~hist_q;

  assign wr_en   = bus.cfg_we_i && (bus.cfg_addr_i == ADDR_ENABLE);
  assign wr_pend = bus.cfg_we_i && (bus.cfg_addr_i == ADDR_PENDING);
  assign wr_vec  = bus.cfg_we_i && (bus.cfg_addr_i == ADDR_VEC_BASE);

  // A fresh edge outranks any clear in the same cycle.
  always_comb begin
    clr_w1c = wr_pend ? bus.cfg_wdata_i[NUM_SRC-1:0] : '0;
    clr_ack = '0;
    if (ack_fire) clr_ack[id_q] = 1'b1;
    pend_d = (pend_q & ~(clr_w1c | clr_ack)) | edge_det;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q   <= '0;
      gie_q  <= 1'b0;
      vec_q  <= '0;
      pend_q <= '0;
    end else begin
      if (wr_en) begin
        en_q  <= bus.cfg_wdata_i[NUM_SRC-1:0];
        gie_q <= bus.cfg_wdata_i[GIE_BIT];
      end
      if (wr_vec) vec_q <= {bus.cfg_wdata_i[31:2], 2'b00};
      pend_q <= pend_d;
    end
  end

  assign masked = pend_q & en_q;

  intr_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio (
    .req_i   (masked),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  assign id_live = gie_q && pend_q[id_q] && en_q[id_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      req_q   <= req_d;
    end
  end

  // Ack is checked before the withdraw condition so a coincident ack wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (gie_q && enc_valid) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (bus.irq_ack_i)  state_d = ST_SERVICE;
        else if (!id_live)  state_d = ST_IDLE;
      end
      ST_SERVICE: begin
        if (bus.irq_done_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ack_fire = (state_q == ST_REQ) && bus.irq_ack_i;
    req_d    = (state_d == ST_REQ);
    id_d     = id_q;
    if ((state_q == ST_IDLE) && (state_d == ST_REQ)) id_d = enc_idx;
  end

  always_comb begin
    bus.cfg_rdata_o = '0;
    case (bus.cfg_addr_i)
      ADDR_ENABLE: begin
        bus.cfg_rdata_o[NUM_SRC-1:0] = en_q;
        bus.cfg_rdata_o[GIE_BIT]     = gie_q;
      end
      ADDR_PENDING:  bus.cfg_rdata_o[NUM_SRC-1:0] = pend_q;
      ADDR_VEC_BASE: bus.cfg_rdata_o = vec_q;
      ADDR_STATUS:   bus.cfg_rdata_o = pack_status(state_q, STATUS_ID_W'(id_q));
      default:       bus.cfg_rdata_o = '0;
    endcase
  end

  assign bus.irq_req_o    = req_q;
  assign bus.irq_id_o     = id_q;
  assign bus.irq_vector_o = vec_q + (32'(id_q) << 2);
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: requests are scored by a monitor against an
// expected queue, register/state checks are made inline.
module tb_intr_ctrl;
  import intr_ctrl_pkg::*;

  localparam int NUM_SRC = 8;
  localparam int ID_W    = 3;
  localparam int EW      = ID_W + 32;

  logic               clk;
  logic               reset;
  logic [NUM_SRC-1:0] irq_i;
  intr_state_e        dbg_state;

  intr_ctrl_if #(.ID_W(ID_W)) bus ();

  intr_ctrl #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_i       (irq_i),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  logic          req_prev = 1'b0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_we_i    = 1'b1;
    bus.cfg_addr_i  = a;
    bus.cfg_wdata_i = d;
    tick();
    bus.cfg_we_i    = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus.cfg_addr_i = a;
    #1;
    check(name, 64'(bus.cfg_rdata_o), 64'(exp));
  endtask

  task automatic ack_pulse();
    bus.irq_ack_i = 1'b1;
    tick();
    bus.irq_ack_i = 1'b0;
  endtask

  task automatic done_pulse();
    bus.irq_done_i = 1'b1;
    tick();
    bus.irq_done_i = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!bus.irq_req_o && n < 20) begin
      tick();
      n++;
    end
    if (!bus.irq_req_o) begin
      total++;
      bad++;
      $display("FAIL %s: got no irq_req_o within 20 cycles required request", name);
    end
  endtask

  task automatic push_exp(input logic [ID_W-1:0] id, input logic [31:0] vec);
    exp_q.push_back({id, vec});
  endtask

  function automatic logic [31:0] status(input intr_state_e st, input int id);
    return 32'(st) | (32'(id) << 8);
  endfunction

  // scoreboard monitor: scores every rising edge of irq_req_o
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (bus.irq_req_o && !req_prev) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_req: got id=%0d vec=0x%0h required none",
                 bus.irq_id_o, bus.irq_vector_o);
      end else begin
        e = exp_q.pop_front();
        check("req_id_vec", 64'({bus.irq_id_o, bus.irq_vector_o}), 64'(e));
      end
    end
    req_prev = bus.irq_req_o;
  end

  initial begin
    reset = 1'b1;
    irq_i = '0;
    bus.cfg_we_i    = 1'b0;
    bus.cfg_addr_i  = 2'd0;
    bus.cfg_wdata_i = '0;
    bus.irq_ack_i   = 1'b0;
    bus.irq_done_i  = 1'b0;
    tick(3);
    reset = 1'b0;
    tick();

    // reset state
    check("rst_req", 64'(bus.irq_req_o), 64'd0);
    check("rst_vector", 64'(bus.irq_vector_o), 64'd0);
    check_reg("rst_enable", ADDR_ENABLE, 32'h0);
    check_reg("rst_pending", ADDR_PENDING, 32'h0);
    check_reg("rst_vecbase", ADDR_VEC_BASE, 32'h0);
    check_reg("rst_status", ADDR_STATUS, 32'h0);

    // register masking
    cfg_write(ADDR_ENABLE, 32'hFFFF_FFFF);
    check_reg("en_mask", ADDR_ENABLE, 32'h8000_00FF);
    cfg_write(ADDR_VEC_BASE, 32'h0000_0103);
    check_reg("vec_align", ADDR_VEC_BASE, 32'h0000_0100);

    // single source, latency
    cfg_write(ADDR_ENABLE, 32'h8000_0004);
    push_exp(3'd2, 32'h108);
    irq_i[2] = 1'b1;
    tick(3);
    check("lat_early", 64'(bus.irq_req_o), 64'd0);
    tick();
    check("lat_req", 64'(bus.irq_req_o), 64'd1);
    irq_i[2] = 1'b0;
    ack_pulse();
    check("svc_req_low", 64'(bus.irq_req_o), 64'd0);
    check_reg("svc_status", ADDR_STATUS, status(ST_SERVICE, 2));
    check_reg("svc_pend_clr", ADDR_PENDING, 32'h0);
    done_pulse();
    check_reg("done_status", ADDR_STATUS, status(ST_IDLE, 2));

    // priority with wrap-around vector
    cfg_write(ADDR_VEC_BASE, 32'hFFFF_FFF0);
    cfg_write(ADDR_ENABLE, 32'h8000_00FF);
    push_exp(3'd1, 32'hFFFF_FFF4);
    push_exp(3'd5, 32'h0000_0004);
    irq_i = 8'h22;
    wait_req("req_prio_a");
    irq_i = '0;
    check_reg("prio_pend_both", ADDR_PENDING, 32'h22);
    ack_pulse();
    check_reg("prio_svc1", ADDR_STATUS, status(ST_SERVICE, 1));
    ack_pulse();
    check_reg("ack_in_svc_status", ADDR_STATUS, status(ST_SERVICE, 1));
    check_reg("ack_in_svc_pend", ADDR_PENDING, 32'h20);
    done_pulse();
    wait_req("req_prio_b");
    check_reg("prio_pend5", ADDR_PENDING, 32'h20);
    check_reg("prio_status5", ADDR_STATUS, status(ST_REQ, 5));
    ack_pulse();
    done_pulse();
    check_reg("prio_pend_empty", ADDR_PENDING, 32'h0);
    done_pulse();
    check_reg("done_in_idle_status", ADDR_STATUS, status(ST_IDLE, 5));
    check_reg("done_in_idle_pend", ADDR_PENDING, 32'h0);

    // withdraw on global disable
    cfg_write(ADDR_VEC_BASE, 32'h0000_0100);
    push_exp(3'd3, 32'h10C);
    irq_i[3] = 1'b1;
    wait_req("req_withdraw");
    irq_i[3] = 1'b0;
    cfg_write(ADDR_ENABLE, 32'h8000_0000);
    tick();
    check("wd_req_low", 64'(bus.irq_req_o), 64'd0);
    check("wd_state", 64'(dbg_state), 64'(ST_IDLE));
    check_reg("wd_pend_kept", ADDR_PENDING, 32'h08);
    cfg_write(ADDR_PENDING, 32'h08);
    check_reg("w1c_pend", ADDR_PENDING, 32'h0);

    // ack coincides with a new edge on the same source
    cfg_write(ADDR_ENABLE, 32'h8000_00FF);
    push_exp(3'd3, 32'h10C);
    irq_i[3] = 1'b1;
    wait_req("req_setwins");
    irq_i[3] = 1'b0;
    tick(4);
    irq_i[3] = 1'b1;
    tick(2);
    bus.irq_ack_i = 1'b1;
    tick();
    bus.irq_ack_i = 1'b0;
    irq_i[3] = 1'b0;
    check("setwins_state", 64'(dbg_state), 64'(ST_SERVICE));
    check_reg("setwins_pend", ADDR_PENDING, 32'h08);
    push_exp(3'd3, 32'h10C);
    done_pulse();
    wait_req("req_rereq");
    ack_pulse();
    done_pulse();
    check_reg("rereq_pend_empty", ADDR_PENDING, 32'h0);

    // reset during service
    push_exp(3'd0, 32'h100);
    irq_i = 8'hFF;
    wait_req("req_all");
    ack_pulse();
    irq_i = '0;
    tick(3);
    irq_i = 8'hFF;
    tick(4);
    check_reg("all_pend", ADDR_PENDING, 32'hFF);
    reset = 1'b1;
    #1;
    check("rst_mid_req", 64'(bus.irq_req_o), 64'd0);
    check_reg("rst_mid_status", ADDR_STATUS, 32'h0);
    check_reg("rst_mid_pend", ADDR_PENDING, 32'h0);
    tick(2);
    reset = 1'b0;
    tick(4);
    check_reg("post_rst_pend", ADDR_PENDING, 32'hFF);
    check_reg("post_rst_enable", ADDR_ENABLE, 32'h0);
    check_reg("post_rst_status", ADDR_STATUS, 32'h0);
    push_exp(3'd0, 32'h0);
    cfg_write(ADDR_ENABLE, 32'h8000_00FF);
    wait_req("req_post_rst");
    ack_pulse();
    cfg_write(ADDR_PENDING, 32'hFF);
    done_pulse();
    irq_i = '0;
    tick(4);
    check("final_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
